// File: rtl/neighbor_table_update.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : neighbor_table_update                                           |
// | Purpose  : Folds decoded beacons into the neighbour/cluster/sink tables.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module neighbor_table_update #(
    parameter int                    WORD_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] NBR_BASE   = 16'h0048,
    parameter logic [WORD_WIDTH-1:0] CLU_BASE   = 16'h00C8,
    parameter logic [WORD_WIDTH-1:0] SINK_BASE  = 16'h0008,
    parameter int                    MAX_NBR    = 64,
    parameter int                    MAX_SINK   = 16
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  beacon_valid,
    output logic                  beacon_ready,
    input  logic [WORD_WIDTH-1:0] beacon_node_id,
    input  logic [WORD_WIDTH-1:0] beacon_cluster,
    input  logic                  beacon_is_sink,
    output logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic [6:0]            nbr_count,
    output logic [4:0]            sink_count,
    output logic                  done,
    output logic                  dropped
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_n_rd     = 4'd1;
    localparam logic [3:0] c_st_n_cmp    = 4'd2;
    localparam logic [3:0] c_st_n_upd    = 4'd3;
    localparam logic [3:0] c_st_n_app_id = 4'd4;
    localparam logic [3:0] c_st_n_app_cl = 4'd5;
    localparam logic [3:0] c_st_s_chk    = 4'd6;
    localparam logic [3:0] c_st_s_rd     = 4'd7;
    localparam logic [3:0] c_st_s_cmp    = 4'd8;
    localparam logic [3:0] c_st_s_app    = 4'd9;
    localparam logic [3:0] c_st_done     = 4'd10;

    localparam logic [6:0] c_nbr_full  = 7'(MAX_NBR);
    localparam logic [4:0] c_sink_full = 5'(MAX_SINK);

    logic [3:0]            r_state,     w_state;
    logic [6:0]            r_idx,       w_idx;
    logic [WORD_WIDTH-1:0] r_node,      w_node;
    logic [WORD_WIDTH-1:0] r_cluster,   w_cluster;
    logic                  r_is_sink,   w_is_sink;
    logic                  r_drop,      w_drop;
    logic [6:0]            r_nbr_count, w_nbr_count;
    logic [4:0]            r_sink_count, w_sink_count;
    logic [WORD_WIDTH-1:0] r_address,   w_address;
    logic [WORD_WIDTH-1:0] r_data_out,  w_data_out;
    logic                  r_wr_en,     w_wr_en;
    logic [6:0]            w_idx_inc;
    logic [6:0]            w_sink_count_ext;

    // Table word address: base + 2*index, wrapping at the word width.
    function automatic logic [WORD_WIDTH-1:0] f_addr(input logic [WORD_WIDTH-1:0] base,
                                                     input logic [6:0]            idx);
        logic [WORD_WIDTH-1:0] off;
        off      = '0;
        off[7:1] = idx;
        return base + off;
    endfunction

    assign w_idx_inc        = r_idx + 7'd1;
    assign w_sink_count_ext = {2'b00, r_sink_count};

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_node       = r_node;
        w_cluster    = r_cluster;
        w_is_sink    = r_is_sink;
        w_drop       = r_drop;
        w_nbr_count  = r_nbr_count;
        w_sink_count = r_sink_count;
        w_address    = r_address;
        w_data_out   = r_data_out;
        w_wr_en      = 1'b0;

        // Memory-port registers are loaded for the state being entered.
        case (r_state)
            c_st_idle: begin
                if (beacon_valid) begin
                    w_node    = beacon_node_id;
                    w_cluster = beacon_cluster;
                    w_is_sink = beacon_is_sink;
                    w_idx     = 7'd0;
                    w_drop    = 1'b0;
                    if (r_nbr_count == 7'd0) begin
                        w_state    = c_st_n_app_id;
                        w_address  = f_addr(NBR_BASE, r_nbr_count);
                        w_data_out = beacon_node_id;
                        w_wr_en    = 1'b1;
                    end else begin
                        w_state   = c_st_n_rd;
                        w_address = NBR_BASE;
                    end
                end
            end
            c_st_n_rd: w_state = c_st_n_cmp;
            c_st_n_cmp: begin
                if (data_in == r_node) begin
                    w_state    = c_st_n_upd;
                    w_address  = f_addr(CLU_BASE, r_idx);
                    w_data_out = r_cluster;
                    w_wr_en    = 1'b1;
                end else if (w_idx_inc < r_nbr_count) begin
                    w_idx     = w_idx_inc;
                    w_state   = c_st_n_rd;
                    w_address = f_addr(NBR_BASE, w_idx_inc);
                end else if (r_nbr_count == c_nbr_full) begin
                    w_drop  = 1'b1;
                    w_state = c_st_s_chk;
                end else begin
                    w_state    = c_st_n_app_id;
                    w_address  = f_addr(NBR_BASE, r_nbr_count);
                    w_data_out = r_node;
                    w_wr_en    = 1'b1;
                end
            end
            c_st_n_upd: w_state = c_st_s_chk;
            c_st_n_app_id: begin
                w_state    = c_st_n_app_cl;
                w_address  = f_addr(CLU_BASE, r_nbr_count);
                w_data_out = r_cluster;
                w_wr_en    = 1'b1;
            end
            c_st_n_app_cl: begin
                w_state = c_st_s_chk;
                if (r_nbr_count != c_nbr_full) begin
                    w_nbr_count = r_nbr_count + 7'd1;
                end
            end
            c_st_s_chk: begin
                if (!r_is_sink) begin
                    w_state = c_st_done;
                end else if (r_sink_count == 5'd0) begin
                    w_state    = c_st_s_app;
                    w_address  = f_addr(SINK_BASE, w_sink_count_ext);
                    w_data_out = r_node;
                    w_wr_en    = 1'b1;
                end else begin
                    w_idx     = 7'd0;
                    w_state   = c_st_s_rd;
                    w_address = SINK_BASE;
                end
            end
            c_st_s_rd: w_state = c_st_s_cmp;
            c_st_s_cmp: begin
                if (data_in == r_node) begin
                    w_state = c_st_done;
                end else if (w_idx_inc < w_sink_count_ext) begin
                    w_idx     = w_idx_inc;
                    w_state   = c_st_s_rd;
                    w_address = f_addr(SINK_BASE, w_idx_inc);
                end else if (r_sink_count == c_sink_full) begin
                    w_drop  = 1'b1;
                    w_state = c_st_done;
                end else begin
                    w_state    = c_st_s_app;
                    w_address  = f_addr(SINK_BASE, w_sink_count_ext);
                    w_data_out = r_node;
                    w_wr_en    = 1'b1;
                end
            end
            c_st_s_app: begin
                w_state = c_st_done;
                if (r_sink_count != c_sink_full) begin
                    w_sink_count = r_sink_count + 5'd1;
                end
            end
            c_st_done: w_state = c_st_idle;
            default:   w_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state      <= c_st_idle;
            r_idx        <= 7'd0;
            r_node       <= '0;
            r_cluster    <= '0;
            r_is_sink    <= 1'b0;
            r_drop       <= 1'b0;
            r_nbr_count  <= 7'd0;
            r_sink_count <= 5'd0;
            r_address    <= NBR_BASE;
            r_data_out   <= '0;
            r_wr_en      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_node       <= w_node;
            r_cluster    <= w_cluster;
            r_is_sink    <= w_is_sink;
            r_drop       <= w_drop;
            r_nbr_count  <= w_nbr_count;
            r_sink_count <= w_sink_count;
            r_address    <= w_address;
            r_data_out   <= w_data_out;
            r_wr_en      <= w_wr_en;
        end
    end

    assign beacon_ready = (r_state == c_st_idle);
    assign done         = (r_state == c_st_done);
    assign dropped      = (r_state == c_st_done) && r_drop;
    assign address      = r_address;
    assign data_out     = r_data_out;
    assign wr_en        = r_wr_en;
    assign nbr_count    = r_nbr_count;
    assign sink_count   = r_sink_count;

endmodule
`default_nettype wire

// File: tb/tb_neighbor_table_update.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_neighbor_table_update                                        |
// | Purpose  : Directed beacons against a table-level reference model.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_neighbor_table_update;

    localparam logic [15:0] c_nbr  = 16'h0048;
    localparam logic [15:0] c_clu  = 16'h00C8;
    localparam logic [15:0] c_sink = 16'h0008;

    logic        clock = 1'b0;
    logic        nrst = 1'b0;
    logic        beacon_valid = 1'b0;
    logic        beacon_ready;
    logic [15:0] beacon_node_id = 16'd0;
    logic [15:0] beacon_cluster = 16'd0;
    logic        beacon_is_sink = 1'b0;
    logic [15:0] address;
    logic [15:0] data_in = 16'd0;
    logic [15:0] data_out;
    logic        wr_en;
    logic [6:0]  nbr_count;
    logic [4:0]  sink_count;
    logic        done;
    logic        dropped;

    neighbor_table_update dut (
        .clock          (clock),
        .nrst           (nrst),
        .beacon_valid   (beacon_valid),
        .beacon_ready   (beacon_ready),
        .beacon_node_id (beacon_node_id),
        .beacon_cluster (beacon_cluster),
        .beacon_is_sink (beacon_is_sink),
        .address        (address),
        .data_in        (data_in),
        .data_out       (data_out),
        .wr_en          (wr_en),
        .nbr_count      (nbr_count),
        .sink_count     (sink_count),
        .done           (done),
        .dropped        (dropped)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: data appears the cycle after its address.
    logic [15:0] mem [0:1023];
    always @(posedge clock) begin
        if (wr_en) mem[address[9:0]] <= data_out;
        data_in <= mem[address[9:0]];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_nbr[$];
    int          m_sink[$];
    logic [15:0] exp_wa[$];
    logic [15:0] exp_wd[$];
    bit          exp_busy = 1'b0;
    bit          exp_drop = 1'b0;
    int          exp_lat  = 0;
    int          last_lat = 0;
    bit          last_drop = 1'b0;
    logic [15:0] cmp_a, cmp_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    // Table-level model: what gets written, whether anything is refused,
    // and how many cycles the lookup costs (2 per probe, 1 per write/step).
    task automatic model(input logic [15:0] node, input logic [15:0] cl, input logic sink);
        int f, sf, b, n;
        f = -1; sf = -1; b = 0;
        exp_drop = 1'b0;
        n = m_nbr.size();
        foreach (m_nbr[i]) if (f < 0 && m_nbr[i] == int'(node)) f = i;
        if (f >= 0) begin
            b += 2 * (f + 1) + 1;
            push_wr(16'(c_clu + 2 * f), cl);
        end else begin
            b += 2 * n;
            if (n == 64) exp_drop = 1'b1;
            else begin
                b += 2;
                push_wr(16'(c_nbr + 2 * n), node);
                push_wr(16'(c_clu + 2 * n), cl);
                m_nbr.push_back(int'(node));
            end
        end
        b += 1;
        if (sink) begin
            n = m_sink.size();
            foreach (m_sink[i]) if (sf < 0 && m_sink[i] == int'(node)) sf = i;
            if (sf >= 0) b += 2 * (sf + 1);
            else begin
                b += 2 * n;
                if (n == 16) exp_drop = 1'b1;
                else begin
                    b += 1;
                    push_wr(16'(c_sink + 2 * n), node);
                    m_sink.push_back(int'(node));
                end
            end
        end
        exp_lat = b + 1;
    endtask

    task automatic model_reset();
        m_nbr.delete();
        m_sink.delete();
        exp_wa.delete();
        exp_wd.delete();
        exp_busy = 1'b0;
    endtask

    always @(negedge clock) begin
        if (nrst) begin
            check("ready", 32'(beacon_ready), 32'(!exp_busy));
            if (wr_en) begin
                if (exp_wa.size() == 0) begin
                    check("unexpected_write_addr", 32'(address), 32'h1_0000);
                end else begin
                    cmp_a = exp_wa.pop_front();
                    cmp_d = exp_wd.pop_front();
                    check("write_addr", 32'(address), 32'(cmp_a));
                    check("write_data", 32'(data_out), 32'(cmp_d));
                end
            end
            if (done) begin
                check("done_expected", 32'(exp_busy), 32'd1);
                check("dropped", 32'(dropped), 32'(exp_drop));
                check("nbr_count", 32'(nbr_count), 32'(m_nbr.size()));
                check("sink_count", 32'(sink_count), 32'(m_sink.size()));
                check("writes_pending", 32'(exp_wa.size()), 32'd0);
                exp_busy = 1'b0;
            end else begin
                check("dropped_idle", 32'(dropped), 32'd0);
            end
        end
    end

    task automatic send_start(input logic [15:0] node, input logic [15:0] cl,
                              input logic sink, input bit hold);
        int w;
        w = 0;
        @(negedge clock);
        while (!beacon_ready && w < 500) begin
            @(negedge clock);
            w++;
        end
        if (!beacon_ready) check("ready_timeout", 32'(beacon_ready), 32'd1);
        model(node, cl, sink);
        beacon_node_id = node;
        beacon_cluster = cl;
        beacon_is_sink = sink;
        beacon_valid   = 1'b1;
        @(posedge clock);
        #1;
        exp_busy = 1'b1;
        if (hold) begin
            beacon_node_id = 16'd777;
            beacon_cluster = 16'd8;
            beacon_is_sink = 1'b0;
        end else begin
            beacon_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!done && lat < 1000);
        if (!done) check("done_timeout", 32'(done), 32'd1);
        last_lat  = lat;
        last_drop = dropped;
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic send(input logic [15:0] node, input logic [15:0] cl, input logic sink);
        send_start(node, cl, sink, 1'b0);
        wait_done();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
        repeat (3) @(negedge clock);
        check("rst_address", 32'(address), 32'h48);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_nbr_count", 32'(nbr_count), 32'd0);
        check("rst_sink_count", 32'(sink_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_ready", 32'(beacon_ready), 32'd1);
        #1 nrst = 1'b1;

        // T1 / T2 / T3
        send(16'd5, 16'd2, 1'b0);
        check("t1_lat", 32'(last_lat), 32'd4);
        check("t1_mem48", 32'(mem[10'h48]), 32'd5);
        check("t1_memC8", 32'(mem[10'hC8]), 32'd2);
        check("t1_cnt", 32'(nbr_count), 32'd1);
        send(16'd5, 16'd7, 1'b0);
        check("t2_lat", 32'(last_lat), 32'd5);
        check("t2_memC8", 32'(mem[10'hC8]), 32'd7);
        send(16'd9, 16'd3, 1'b1);
        check("t3_lat", 32'(last_lat), 32'd7);
        check("t3_mem4A", 32'(mem[10'h4A]), 32'd9);
        check("t3_memCA", 32'(mem[10'hCA]), 32'd3);
        check("t3_mem08", 32'(mem[10'h08]), 32'd9);
        send(16'd9, 16'd3, 1'b1);
        check("t3b_lat", 32'(last_lat), 32'd9);
        check("t3b_sink", 32'(sink_count), 32'd1);

        // T5: valid held through a busy period; 777 only taken after done
        send_start(16'd20, 16'd4, 1'b0, 1'b1);
        wait_done();
        check("t5_lat", 32'(last_lat), 32'd8);
        @(negedge clock);
        model(16'd777, 16'd8, 1'b0);
        @(posedge clock);
        #1;
        exp_busy = 1'b1;
        beacon_valid = 1'b0;
        wait_done();
        check("t5_lat777", 32'(last_lat), 32'd10);
        check("t5_mem4E", 32'(mem[10'h4E]), 32'd777);

        // T4: fill neighbour table, then overflow; then sinks
        for (int k = 0; k < 60; k++) send(16'(1000 + k), 16'(k), 1'b0);
        check("t4_full", 32'(nbr_count), 32'd64);
        send(16'd100, 16'd1, 1'b0);
        check("t4_lat", 32'(last_lat), 32'd130);
        check("t4_drop", 32'(last_drop), 32'd1);
        check("t4_no_overflow_write", 32'(mem[10'hC8]), 32'd7);
        for (int k = 0; k < 15; k++) send(16'(1000 + k), 16'd50, 1'b1);
        check("t4_sink_full", 32'(sink_count), 32'd16);
        send(16'd1015, 16'd51, 1'b1);
        check("t4s_lat", 32'(last_lat), 32'd75);
        check("t4s_drop", 32'(last_drop), 32'd1);
        check("t4s_no_write", 32'(mem[10'h28]), 32'd0);
        check("t4s_cnt", 32'(sink_count), 32'd16);

        // T6: reset in the middle of an append
        @(negedge clock);
        nrst = 1'b0;
        model_reset();
        @(negedge clock);
        #1 nrst = 1'b1;
        send_start(16'd50, 16'd6, 1'b0, 1'b0);
        w = 0;
        while (!(wr_en && address == c_clu) && w < 10) begin
            @(negedge clock);
            w++;
        end
        check("t6_reach_app_cl", 32'(wr_en && address == c_clu), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("t6_wr_en", 32'(wr_en), 32'd0);
        check("t6_nbr_cnt", 32'(nbr_count), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        #1 nrst = 1'b1;
        @(negedge clock);
        check("t6_ready", 32'(beacon_ready), 32'd1);
        check("t6_memC8_kept", 32'(mem[10'hC8]), 32'd7);
        send(16'd60, 16'd9, 1'b0);
        check("t6_lat", 32'(last_lat), 32'd4);
        check("t6_mem48", 32'(mem[10'h48]), 32'd60);
        check("t6_memC8", 32'(mem[10'hC8]), 32'd9);
        check("t6_cnt", 32'(nbr_count), 32'd1);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
